// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and pulls each instruction
// from program memory as an opcode word followed by an immediate word.
module fetch_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pc_inc,
    input  logic            pc_ie,
    input  logic [PC_W-1:0] pc_in,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            pm_req,
    output logic [PC_W:0]   pm_addr,
    input  logic            pm_ack,
    input  logic [15:0]     pm_data,
    output logic [15:0]     instr,
    output logic [15:0]     imm,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc
);

    typedef enum logic [1:0] {
        F_OP,
        F_IMM,
        HOLD
    } state_t;

    state_t          state_q, state_n;
    logic [PC_W-1:0] pc_q, pc_n;
    logic            req_q, req_n;
    logic [PC_W:0]   addr_q, addr_n;
    logic [15:0]     instr_q, instr_n;
    logic [15:0]     imm_q, imm_n;
    logic            valid_q, valid_n;
    logic            discard_q, discard_n;
    logic            ack;

    assign ack = req_q && pm_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= F_OP;
            pc_q      <= RESET_PC;
            req_q     <= 1'b0;
            addr_q    <= '0;
            instr_q   <= '0;
            imm_q     <= '0;
            valid_q   <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            pc_q      <= pc_n;
            req_q     <= req_n;
            addr_q    <= addr_n;
            instr_q   <= instr_n;
            imm_q     <= imm_n;
            valid_q   <= valid_n;
            discard_q <= discard_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        pc_n      = pc_q;
        req_n     = req_q;
        addr_n    = addr_q;
        instr_n   = instr_q;
        imm_n     = imm_q;
        valid_n   = valid_q;
        discard_n = discard_q;

        if (redirect) begin
            pc_n    = redirect_pc;
            valid_n = 1'b0;
            instr_n = '0;
            state_n = F_OP;
            // An unacked request cannot be withdrawn; its data is dropped later.
            if (req_q && !pm_ack) begin
                discard_n = 1'b1;
            end else begin
                discard_n = 1'b0;
                req_n     = 1'b1;
                addr_n    = {redirect_pc, 1'b0};
            end
        end else begin
            unique case (state_q)
                F_OP: begin
                    if (!req_q) begin
                        req_n  = 1'b1;
                        addr_n = {pc_q, 1'b0};
                    end else if (ack) begin
                        if (discard_q) begin
                            discard_n = 1'b0;
                            addr_n    = {pc_q, 1'b0};
                        end else begin
                            instr_n = pm_data;
                            addr_n  = {pc_q, 1'b1};
                            state_n = F_IMM;
                        end
                    end
                end
                F_IMM: begin
                    if (ack) begin
                        imm_n   = pm_data;
                        valid_n = 1'b1;
                        req_n   = 1'b0;
                        state_n = HOLD;
                    end
                end
                HOLD: begin
                    if (valid_q && (pc_ie || pc_inc)) begin
                        if (pc_ie) begin
                            pc_n = pc_in;
                        end else begin
                            pc_n = pc_q + 1'b1;
                        end
                        valid_n = 1'b0;
                        instr_n = '0;
                        req_n   = 1'b1;
                        addr_n  = {pc_n, 1'b0};
                        state_n = F_OP;
                    end
                end
                default: begin
                    state_n = F_OP;
                end
            endcase
        end
    end

    assign pm_req      = req_q;
    assign pm_addr     = addr_q;
    assign instr       = valid_q ? instr_q : 16'h0000;
    assign imm         = imm_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;

endmodule
